// File: rtl/misc_in_debounce.sv
`default_nettype none
// ============================================================================
// Module   : misc_in_debounce
// Purpose  : Per-bit synchronizer and debounce filter for discrete board inputs.
//            Each bit has a sticky edge flag; irq is the OR of all edge flags.
// Revision : 1.0 - initial release
// ============================================================================
module misc_in_debounce #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] edge_flags,
    output logic             irq
);

    localparam int              CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  synced;
    logic [WIDTH-1:0]                  deb_q;
    logic [WIDTH-1:0]                  deb_d;
    logic [WIDTH-1:0]                  flag_q;
    logic [WIDTH-1:0]                  flag_d;

    // Stage 0 samples the asynchronous inputs; the last stage is the synced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             change;

            always_comb begin
                cnt_d    = '0;
                deb_d[i] = deb_q[i];
                change   = 1'b0;
                if (synced[i] != deb_q[i]) begin
                    if (cnt_q == CNT_MAX) begin
                        deb_d[i] = synced[i];
                        change   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // A new edge takes priority over a clear strobe on the same cycle.
            always_comb begin
                flag_d[i] = change | (flag_q[i] & ~edge_clr[i]);
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q  <= '0;
            flag_q <= '0;
        end else begin
            deb_q  <= deb_d;
            flag_q <= flag_d;
        end
    end

    assign debounced  = deb_q;
    assign edge_flags = flag_q;
    assign irq        = |flag_q;

endmodule
`default_nettype wire

// File: tb/tb_misc_in_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_misc_in_debounce
// Purpose  : Directed self-checking bench for misc_in_debounce (default build
//            plus a SYNC_STAGES=3 / DB_CYCLES=2 build).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_misc_in_debounce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] raw_in, edge_clr, debounced, edge_flags;
    logic       irq;
    logic [7:0] raw2, clr2, deb2, flags2;
    logic       irq2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    misc_in_debounce u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .edge_clr   (edge_clr),
        .debounced  (debounced),
        .edge_flags (edge_flags),
        .irq        (irq)
    );

    misc_in_debounce #(.WIDTH(8), .SYNC_STAGES(3), .DB_CYCLES(2)) u_dut_fast (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw2),
        .edge_clr   (clr2),
        .debounced  (deb2),
        .edge_flags (flags2),
        .irq        (irq2)
    );

    // Advance n rising edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        raw_in   = 8'h00;
        edge_clr = 8'h00;
        raw2     = 8'h00;
        clr2     = 8'h00;
        #23;
        checks++;
        if (debounced !== 8'h00 || edge_flags !== 8'h00 || irq !== 1'b0) begin
            $display("FAIL reset_in: deb=%h flags=%h irq=%b, want 00 00 0", debounced, edge_flags, irq);
            errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick(100);
        checks++;
        if (debounced !== 8'h00 || edge_flags !== 8'h00 || irq !== 1'b0) begin
            $display("FAIL idle_100: deb=%h flags=%h irq=%b, want 00 00 0", debounced, edge_flags, irq);
            errors++;
        end
    endtask

    task automatic test_rise;
        raw_in = 8'h01;
        tick(17);
        checks++;
        if (debounced !== 8'h00) begin
            $display("FAIL rise_edge17: deb=%h want 00", debounced);
            errors++;
        end
        tick(1);
        checks++;
        if (debounced !== 8'h01 || edge_flags !== 8'h01 || irq !== 1'b1) begin
            $display("FAIL rise_edge18: deb=%h flags=%h irq=%b, want 01 01 1", debounced, edge_flags, irq);
            errors++;
        end
        edge_clr = 8'h01;
        tick(1);
        edge_clr = 8'h00;
        checks++;
        if (edge_flags !== 8'h00 || irq !== 1'b0 || debounced !== 8'h01) begin
            $display("FAIL rise_clear: deb=%h flags=%h irq=%b, want 01 00 0", debounced, edge_flags, irq);
            errors++;
        end
    endtask

    task automatic test_glitch;
        raw_in[3] = 1'b1;
        tick(15);
        raw_in[3] = 1'b0;
        tick(1);
        raw_in[3] = 1'b1;
        tick(15);
        raw_in[3] = 1'b0;
        tick(40);
        checks++;
        if (debounced !== 8'h01 || edge_flags !== 8'h00 || irq !== 1'b0) begin
            $display("FAIL glitch_15: deb=%h flags=%h irq=%b, want 01 00 0", debounced, edge_flags, irq);
            errors++;
        end
    endtask

    task automatic test_set_wins;
        raw_in[2] = 1'b1;
        tick(18);
        checks++;
        if (debounced !== 8'h05 || edge_flags !== 8'h04) begin
            $display("FAIL bit2_rise: deb=%h flags=%h, want 05 04", debounced, edge_flags);
            errors++;
        end
        edge_clr = 8'hFB;
        tick(1);
        edge_clr = 8'h00;
        checks++;
        if (edge_flags !== 8'h04) begin
            $display("FAIL clr_unset_bits: flags=%h want 04", edge_flags);
            errors++;
        end
        raw_in[2] = 1'b0;
        tick(17);
        edge_clr = 8'h04;
        tick(1);
        edge_clr = 8'h00;
        checks++;
        if (debounced !== 8'h01 || edge_flags !== 8'h04 || irq !== 1'b1) begin
            $display("FAIL set_beats_clr: deb=%h flags=%h irq=%b, want 01 04 1", debounced, edge_flags, irq);
            errors++;
        end
        edge_clr = 8'h04;
        tick(1);
        edge_clr = 8'h00;
        checks++;
        if (edge_flags !== 8'h00) begin
            $display("FAIL bit2_clear: flags=%h want 00", edge_flags);
            errors++;
        end
    endtask

    task automatic test_reset_high;
        @(negedge clk);
        reset_n = 1'b0;
        raw_in  = 8'hA5;
        @(negedge clk);
        reset_n = 1'b1;
        tick(17);
        checks++;
        if (debounced !== 8'h00) begin
            $display("FAIL a5_edge17: deb=%h want 00", debounced);
            errors++;
        end
        tick(1);
        checks++;
        if (debounced !== 8'hA5 || edge_flags !== 8'hA5 || irq !== 1'b1) begin
            $display("FAIL a5_edge18: deb=%h flags=%h irq=%b, want A5 A5 1", debounced, edge_flags, irq);
            errors++;
        end
        edge_clr = 8'h05;
        tick(1);
        edge_clr = 8'h00;
        checks++;
        if (edge_flags !== 8'hA0) begin
            $display("FAIL multi_clr_a: flags=%h want A0", edge_flags);
            errors++;
        end
        edge_clr = 8'hA0;
        tick(1);
        edge_clr = 8'h00;
        checks++;
        if (edge_flags !== 8'h00 || irq !== 1'b0 || debounced !== 8'hA5) begin
            $display("FAIL multi_clr_b: deb=%h flags=%h irq=%b, want A5 00 0", debounced, edge_flags, irq);
            errors++;
        end
        // Asynchronous assertion mid-cycle while outputs are non-zero.
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (debounced !== 8'h00 || edge_flags !== 8'h00 || irq !== 1'b0) begin
            $display("FAIL async_reset: deb=%h flags=%h irq=%b, want 00 00 0", debounced, edge_flags, irq);
            errors++;
        end
        // Second run: reset on edge 10 discards the pending count.
        @(negedge clk);
        reset_n = 1'b1;
        tick(9);
        @(posedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (debounced !== 8'h00 || edge_flags !== 8'h00 || irq !== 1'b0) begin
            $display("FAIL reset_edge10: deb=%h flags=%h irq=%b, want 00 00 0", debounced, edge_flags, irq);
            errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick(17);
        checks++;
        if (debounced !== 8'h00) begin
            $display("FAIL discard_pending: deb=%h want 00", debounced);
            errors++;
        end
        tick(1);
        checks++;
        if (debounced !== 8'hA5 || edge_flags !== 8'hA5) begin
            $display("FAIL restart_edge18: deb=%h flags=%h, want A5 A5", debounced, edge_flags);
            errors++;
        end
    endtask

    task automatic test_fast;
        logic old_lvl;
        for (int k = 0; k < 4; k++) begin
            old_lvl  = raw2[7];
            raw2[7]  = ~old_lvl;
            tick(4);
            checks++;
            if (deb2[7] !== old_lvl) begin
                $display("FAIL fast_edge4_%0d: deb2=%h want bit7=%b", k, deb2, old_lvl);
                errors++;
            end
            tick(1);
            checks++;
            if (deb2 !== {~old_lvl, 7'h00} || flags2 !== 8'h80 || irq2 !== 1'b1) begin
                $display("FAIL fast_edge5_%0d: deb2=%h flags2=%h irq2=%b, want %h 80 1",
                         k, deb2, flags2, irq2, {~old_lvl, 7'h00});
                errors++;
            end
            clr2 = 8'h80;
            tick(1);
            clr2 = 8'h00;
            checks++;
            if (flags2 !== 8'h00 || irq2 !== 1'b0) begin
                $display("FAIL fast_clr_%0d: flags2=%h irq2=%b, want 00 0", k, flags2, irq2);
                errors++;
            end
            tick(4);
        end
        raw2[7] = 1'b1;
        tick(1);
        raw2[7] = 1'b0;
        tick(10);
        checks++;
        if (deb2 !== 8'h00 || flags2 !== 8'h00) begin
            $display("FAIL fast_pulse1: deb2=%h flags2=%h, want 00 00", deb2, flags2);
            errors++;
        end
    endtask

    initial begin
        test_reset;
        test_rise;
        test_glitch;
        test_set_wins;
        test_reset_high;
        test_fast;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
